// File: rtl/grant_index_pkg.sv
// ---------------------------------------------------------------------------
// grant_index_pkg
// Purpose : Shared widths, buffer-occupancy state encoding and the one-hot
//           to lane-index encode helper for the grant index encoder.
// Contents: IDX_W, NUM_LANES, state_e {EMPTY, ONE, FULL}, encode_onehot().
// ---------------------------------------------------------------------------
package grant_index_pkg;

  localparam int unsigned IDX_W     = 2;
  localparam int unsigned NUM_LANES = 4;

  // Buffer occupancy of the 2-entry output channel
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Lane number of the set bit; only meaningful for a one-hot vector
  function automatic logic [IDX_W-1:0] encode_onehot(input logic [NUM_LANES-1:0] vec);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (vec[i]) begin
        res = IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage : grant_index_pkg

// File: rtl/grant_index_encoder_onehot_check_4.sv
// ---------------------------------------------------------------------------
// onehot_check_4
// Purpose : Combinational classifier for a 4-lane grant vector.
// Ports   :
//   vec_i         in  [3:0] grant vector {g3,g2,g1,g0}
//   is_zero_c_o   out       no lane set
//   is_onehot_c_o out       exactly one lane set
//   idx_c_o       out [1:0] lane index (valid when is_onehot_c_o)
// ---------------------------------------------------------------------------
module onehot_check_4
  import grant_index_pkg::*;
(
  input  logic [NUM_LANES-1:0] vec_i,
  output logic                 is_zero_c_o,
  output logic                 is_onehot_c_o,
  output logic [IDX_W-1:0]     idx_c_o
);

  // Clearing the lowest set bit leaves zero only for a single-bit vector
  always_comb begin
    is_zero_c_o   = (vec_i == '0);
    is_onehot_c_o = !is_zero_c_o &&
                    ((vec_i & (vec_i - NUM_LANES'(1))) == '0);
    idx_c_o       = encode_onehot(vec_i);
  end

endmodule : onehot_check_4

// File: rtl/grant_index_encoder.sv
// ---------------------------------------------------------------------------
// grant_index_encoder
// Purpose : Captures a one-hot 4-lane grant, checks legality, encodes it to a
//           2-bit lane index and delivers it through a 2-entry skid buffer.
// Ports   :
//   clk        in        system clock, rising edge
//   rst        in        synchronous active-high reset
//   g0..g3     in        grant lanes (g3 highest priority)
//   in_valid   in        grant vector valid
//   in_ready   out       vector can be accepted (registered, state only)
//   idx        out [1:0] lane index of head entry
//   out_valid  out       idx valid
//   out_ready  in        downstream accepts idx
//   err        out       sticky: a multi-hot vector was accepted
//   err_vec    out [3:0] first multi-hot vector accepted
//   cnt0..cnt3 out [CNT_W-1:0] saturating per-lane grant counters
//              (present only when GRANT_INDEX_COUNT_EN is defined)
// Optional feature macro: GRANT_INDEX_COUNT_EN
// ---------------------------------------------------------------------------
module grant_index_encoder
  import grant_index_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 g0,
  input  logic                 g1,
  input  logic                 g2,
  input  logic                 g3,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IDX_W-1:0]     idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [NUM_LANES-1:0] err_vec
`ifdef GRANT_INDEX_COUNT_EN
  ,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1,
  output logic [CNT_W-1:0]     cnt2,
  output logic [CNT_W-1:0]     cnt3
`endif
);

  // The buffer is hard-wired to two entries
  if (DEPTH != 2 || CNT_W == 0) begin : g_param_chk
    $error("grant_index_encoder: DEPTH must be 2 and CNT_W must be non-zero");
  end

  logic [NUM_LANES-1:0] vec;
  logic                 chk_zero;
  logic                 chk_onehot;
  logic [IDX_W-1:0]     chk_idx;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     head_q, head_d;
  logic [IDX_W-1:0]     tail_q, tail_d;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 err_q, err_d;
  logic [NUM_LANES-1:0] err_vec_q, err_vec_d;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 bad;

  assign vec = {g3, g2, g1, g0};

  // Input-stage legality check
  onehot_check_4 u_check (
    .vec_i         (vec),
    .is_zero_c_o   (chk_zero),
    .is_onehot_c_o (chk_onehot),
    .idx_c_o       (chk_idx)
  );

  // Handshake qualifiers; only a legal vector is pushed
  always_comb begin
    accept = in_valid && in_ready_q;
    push   = accept && chk_onehot;
    pop    = out_valid_q && out_ready;
    bad    = accept && !chk_zero && !chk_onehot;
  end

  // Occupancy next-state and entry update
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = chk_idx;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head leaves and the new index takes its place
          head_d = chk_idx;
        end else if (push) begin
          state_d = FULL;
          tail_d  = chk_idx;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Sticky error flag; only the first offending vector is kept
  always_comb begin
    err_d     = err_q || bad;
    err_vec_d = err_vec_q;
    if (bad && !err_q) begin
      err_vec_d = vec;
    end
  end

  // State and registered outputs; flags follow the next occupancy state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      err_q       <= 1'b0;
      err_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
      err_q       <= err_d;
      err_vec_q   <= err_vec_d;
    end
  end

  assign idx       = head_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign err       = err_q;
  assign err_vec   = err_vec_q;

`ifdef GRANT_INDEX_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_LANES];
  logic [CNT_W-1:0] cnt_d [NUM_LANES];

  // Saturating per-lane count of legal pushes
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      cnt_d[l] = cnt_q[l];
      if (push && (chk_idx == IDX_W'(l)) && (cnt_q[l] != {CNT_W{1'b1}})) begin
        cnt_d[l] = cnt_q[l] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (rst) begin
        cnt_q[l] <= '0;
      end else begin
        cnt_q[l] <= cnt_d[l];
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule : grant_index_encoder

// File: tb/tb_grant_index_encoder.sv
// ---------------------------------------------------------------------------
// tb_grant_index_encoder
// Purpose : Self-checking bench for grant_index_encoder. A queue-based model
//           of the 2-entry channel predicts every output after each edge.
// ---------------------------------------------------------------------------
module tb_grant_index_encoder;

`ifdef GRANT_INDEX_COUNT_EN
  localparam int unsigned TB_CNT_W = 2;
`else
  localparam int unsigned TB_CNT_W = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] gv;
  logic       in_ready;
  logic [1:0] idx;
  logic       out_valid;
  logic       err;
  logic [3:0] err_vec;
`ifdef GRANT_INDEX_COUNT_EN
  logic [TB_CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         q[$];
  bit         m_err;
  logic [3:0] m_err_vec;
  int         m_cnt[4];

  always #5 clk = ~clk;

  grant_index_encoder #(.DEPTH(2), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .g0        (gv[0]),
    .g1        (gv[1]),
    .g2        (gv[2]),
    .g3        (gv[3]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idx       (idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_vec   (err_vec)
`ifdef GRANT_INDEX_COUNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

`ifdef GRANT_INDEX_COUNT_EN
  function automatic int get_cnt(input int l);
    case (l)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction
`endif

  // Advance the model across one rising edge given the inputs applied
  task automatic model_edge(input logic r, input logic v, input logic [3:0] vec, input logic ordy);
    bit acc;
    bit pop;
    int lane;
    int maxc;
    if (r) begin
      q.delete();
      m_err     = 1'b0;
      m_err_vec = 4'h0;
      for (int l = 0; l < 4; l++) m_cnt[l] = 0;
      return;
    end
    acc  = v && (q.size() < 2);
    pop  = (q.size() > 0) && ordy;
    maxc = (1 << TB_CNT_W) - 1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if ($countones(vec) == 1) begin
        lane = 0;
        for (int i = 0; i < 4; i++) if (vec[i]) lane = i;
        q.push_back(lane);
        if (m_cnt[lane] < maxc) m_cnt[lane]++;
      end else if ($countones(vec) > 1) begin
        if (!m_err) begin
          m_err     = 1'b1;
          m_err_vec = vec;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) check("idx", 32'(idx), 32'(q[0]));
    check("err", 32'(err), 32'(m_err));
    check("err_vec", 32'(err_vec), 32'(m_err_vec));
`ifdef GRANT_INDEX_COUNT_EN
    for (int l = 0; l < 4; l++) check($sformatf("cnt%0d", l), 32'(get_cnt(l)), 32'(m_cnt[l]));
`endif
  endtask

  // Apply inputs for one cycle, step the model, sample #1 after the edge
  task automatic cycle(input logic r, input logic v, input logic [3:0] vec, input logic ordy);
    rst       = r;
    in_valid  = v;
    gv        = vec;
    out_ready = ordy;
    model_edge(r, v, vec, ordy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  logic [3:0] multi_tbl [11];

  initial begin
    logic [3:0] vec;
    logic       r, v, ordy;
    int         sel;

    multi_tbl = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
    rst = 1'b1; in_valid = 1'b0; gv = 4'h0; out_ready = 1'b0;

    // Reset state
    cycle(1, 0, 4'h0, 0);
    cycle(1, 0, 4'h0, 0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);

    // Single legal grant, 1-cycle latency
    cycle(0, 1, 4'b0100, 1);
    check("single_idx", 32'(idx), 32'd2);
    check("single_valid", 32'(out_valid), 32'd1);
    cycle(0, 0, 4'h0, 1);
    check("single_drain", 32'(out_valid), 32'd0);
    check("single_err", 32'(err), 32'd0);

    // Backpressure fill then drain in order
    cycle(0, 1, 4'b1000, 0);
    cycle(0, 1, 4'b0001, 0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", 32'(idx), 32'd3);
    cycle(0, 1, 4'b0010, 0);
    check("full_hold", 32'(idx), 32'd3);
    cycle(0, 0, 4'h0, 1);
    check("full_second", 32'(idx), 32'd0);
    check("full_to_one", 32'(in_ready), 32'd1);
    cycle(0, 0, 4'h0, 1);
    check("full_empty", 32'(out_valid), 32'd0);

    // Push and pop together in ONE
    cycle(0, 1, 4'b0010, 0);
    check("pp_head", 32'(idx), 32'd1);
    cycle(0, 1, 4'b1000, 1);
    check("pp_new_head", 32'(idx), 32'd3);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    cycle(0, 0, 4'h0, 1);

    // Illegal vectors
    cycle(0, 1, 4'b0101, 1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_vec", 32'(err_vec), 32'h5);
    check("ill_noout", 32'(out_valid), 32'd0);
    cycle(0, 1, 4'b1100, 1);
    check("ill_vec_kept", 32'(err_vec), 32'h5);
    cycle(0, 1, 4'b0000, 1);
    check("zero_noout", 32'(out_valid), 32'd0);
    check("zero_err", 32'(err), 32'd1);

    // Reset while FULL flushes everything
    cycle(0, 1, 4'b1000, 0);
    cycle(0, 1, 4'b0100, 0);
    cycle(1, 0, 4'h0, 1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);
    cycle(0, 0, 4'h0, 1);
    check("mid_rst_lost", 32'(out_valid), 32'd0);

`ifdef GRANT_INDEX_COUNT_EN
    // Saturating counter with 2-bit width
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 4'b0010, 1);
      check("cnt1_sat", 32'(cnt1), (k < 3) ? 32'(k + 1) : 32'd3);
      check("cnt0_idle", 32'(cnt0), 32'd0);
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      sel = int'($urandom_range(0, 99));
      if (sel < 65)      vec = 4'(1 << $urandom_range(0, 3));
      else if (sel < 80) vec = 4'h0;
      else if (sel < 88) vec = multi_tbl[$urandom_range(0, 10)];
      else               vec = 4'($urandom);
      v    = ($urandom_range(0, 3) != 0);
      ordy = (i % 400 < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      cycle(r, v, vec, ordy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_grant_index_encoder
